// File: rtl/shared_gf_pkg.sv
// Shared definitions for the masked GF(2^N) multiplier: field constants,
// a shift-and-add field multiply and the share-pair index mapping.
package shared_gf_pkg;

  localparam logic [4:0] GF4_POLY = 5'b10011;
  localparam logic [8:0] GF8_POLY = 9'h11B;

  // Operands are zero-extended to 8 bits; only the low n bits are meaningful.
  function automatic logic [7:0] gf_mul(
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [8:0]  poly,
    input int unsigned n
  );
    logic [8:0] sh;
    logic [8:0] top;
    logic [7:0] acc;
    acc = '0;
    sh  = {1'b0, a};
    top = 9'd1 << n;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) begin
        if (((b >> i) & 8'd1) != 8'd0) acc ^= sh[7:0];
        sh = sh << 1;
        if ((sh & top) != '0) sh ^= poly;
      end
    end
    return acc;
  endfunction

  // Lexicographic index of the unordered share pair {i, j}, i != j.
  function automatic int unsigned pair_idx(
    input int unsigned i,
    input int unsigned j,
    input int unsigned shares
  );
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/gf2n_mul.sv
// Combinational GF(2^N) multiplier reduced modulo POLY.
module gf2n_mul import shared_gf_pkg::*; #(
  parameter int unsigned N    = 4,
  parameter logic [N:0]  POLY = GF4_POLY
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  assign p = N'(gf_mul(8'(a), 8'(b), 9'(POLY), N));

endmodule

// File: rtl/shared_mul_gf2n.sv
// Domain-oriented-masking multiplier over GF(2^N) with any number of shares;
// every cross-domain product is resharing-registered before recombination.
module shared_mul_gf2n import shared_gf_pkg::*; #(
  parameter int unsigned N         = 4,
  parameter logic [N:0]  POLY      = GF4_POLY,
  parameter int unsigned SHARES    = 2,
  parameter int unsigned PIPELINED = 1,
  parameter int unsigned OUT_REG   = 0
) (
  input  logic                             ClkxCI,
  input  logic                             RstxRI,
  input  logic                             EnxSI,
  input  logic                             InValidxSI,
  input  logic [N*SHARES-1:0]              _XxDI,
  input  logic [N*SHARES-1:0]              _YxDI,
  input  logic [N*SHARES*(SHARES-1)/2-1:0] _ZxDI,
  output logic                             OutValidxSO,
  output logic [N*SHARES-1:0]              _QxDO
);

  localparam int unsigned LAT = 1 + OUT_REG;

  logic [N*SHARES*SHARES-1:0] termFlat;
  logic [N*SHARES-1:0]        qFlat;
  logic [LAT-1:0]             validSr;

  for (genvar gi = 0; gi < SHARES; gi++) begin : gRow
    for (genvar gj = 0; gj < SHARES; gj++) begin : gCol
      logic [N-1:0] prod;

      gf2n_mul #(.N(N), .POLY(POLY)) uMul (
        .a (_XxDI[gi*N +: N]),
        .b (_YxDI[gj*N +: N]),
        .p (prod)
      );

      if (gi != gj) begin : gCross
        // C_ij and C_ji share the same fresh mask Z_{pair(i,j)}.
        localparam int unsigned P = pair_idx(gi, gj, SHARES);
        logic [N-1:0] crossQ;
        always_ff @(posedge ClkxCI or posedge RstxRI) begin
          if (RstxRI) crossQ <= '0;
          else if (EnxSI) crossQ <= prod ^ _ZxDI[P*N +: N];
        end
        assign termFlat[(gi*SHARES+gj)*N +: N] = crossQ;
      end else if (PIPELINED != 0) begin : gInnerReg
        logic [N-1:0] innerQ;
        always_ff @(posedge ClkxCI or posedge RstxRI) begin
          if (RstxRI) innerQ <= '0;
          else if (EnxSI) innerQ <= prod;
        end
        assign termFlat[(gi*SHARES+gj)*N +: N] = innerQ;
      end else begin : gInnerComb
        assign termFlat[(gi*SHARES+gj)*N +: N] = prod;
      end
    end
  end

  always_comb begin
    qFlat = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        qFlat[i*N +: N] = qFlat[i*N +: N] ^ termFlat[(i*SHARES+j)*N +: N];
      end
    end
  end

  if (OUT_REG != 0) begin : gOutReg
    logic [N*SHARES-1:0] qReg;
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
      if (RstxRI) qReg <= '0;
      else if (EnxSI) qReg <= qFlat;
    end
    assign _QxDO = qReg;
  end else begin : gOutComb
    assign _QxDO = qFlat;
  end

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) validSr <= '0;
    else if (EnxSI) validSr <= LAT'({validSr, InValidxSI});
  end

  assign OutValidxSO = validSr[LAT-1];

endmodule

// File: tb/tb_shared_mul_gf2n.sv
// Scoreboard bench for shared_mul_gf2n across four parameterisations.
module tb_shared_mul_gf2n;
  import shared_gf_pkg::*;

  typedef struct {
    logic [7:0]  prod;
    logic [31:0] shares;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en;
  always #5 clk = ~clk;

  logic ivA, vA; logic [7:0]  xA, yA, qAo; logic [3:0]  zA;
  logic ivB, vB; logic [23:0] xB, yB, qBo; logic [23:0] zB;
  logic ivC, vC; logic [7:0]  xC, yC, qCo; logic [3:0]  zC;
  logic ivD, vD; logic [15:0] xD, yD, qDo; logic [23:0] zD;

  exp_t sbA[$], sbB[$], sbC[$], sbD[$];
  int   nCmp = 0, nBad = 0;
  bit   edgeEn = 1'b0;

  shared_mul_gf2n #(.N(4), .POLY(5'b10011), .SHARES(2), .PIPELINED(1), .OUT_REG(0)) dutA (
    .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .InValidxSI(ivA),
    ._XxDI(xA), ._YxDI(yA), ._ZxDI(zA), .OutValidxSO(vA), ._QxDO(qAo));
  shared_mul_gf2n #(.N(8), .POLY(9'h11B), .SHARES(3), .PIPELINED(1), .OUT_REG(0)) dutB (
    .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .InValidxSI(ivB),
    ._XxDI(xB), ._YxDI(yB), ._ZxDI(zB), .OutValidxSO(vB), ._QxDO(qBo));
  shared_mul_gf2n #(.N(4), .POLY(5'b10011), .SHARES(2), .PIPELINED(1), .OUT_REG(1)) dutC (
    .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .InValidxSI(ivC),
    ._XxDI(xC), ._YxDI(yC), ._ZxDI(zC), .OutValidxSO(vC), ._QxDO(qCo));
  shared_mul_gf2n #(.N(4), .POLY(5'b10011), .SHARES(4), .PIPELINED(0), .OUT_REG(0)) dutD (
    .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .InValidxSI(ivD),
    ._XxDI(xD), ._YxDI(yD), ._ZxDI(zD), .OutValidxSO(vD), ._QxDO(qDo));

  // Schoolbook carry-less product followed by top-down reduction.
  function automatic logic [7:0] gfRef(input logic [7:0] a, input logic [7:0] b,
                                       input int n, input logic [8:0] poly);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) if (b[i]) acc ^= 16'(a) << i;
    for (int k = 2*n-2; k >= n; k--) if (acc[k]) acc ^= 16'(poly) << (k-n);
    return acc[7:0];
  endfunction

  function automatic logic [7:0] recomb(input logic [31:0] q, input int n, input int s);
    logic [7:0]  r;
    logic [31:0] m;
    r = '0;
    m = (32'd1 << n) - 32'd1;
    for (int i = 0; i < s; i++) r ^= 8'((q >> (i*n)) & m);
    return r;
  endfunction

  function automatic int sbSize(input int which);
    case (which)
      0: return sbA.size();
      1: return sbB.size();
      2: return sbC.size();
      default: return sbD.size();
    endcase
  endfunction

  always @(posedge clk) edgeEn = en && !rst;

  always @(negedge clk) if (edgeEn && !rst && vA) begin : monA
    exp_t e;
    nCmp++;
    if (sbA.size() == 0) begin
      nBad++; $display("FAIL monA_unexpected: got beat q=%h, required no beat", qAo);
    end else begin
      e = sbA.pop_front();
      if (recomb({24'h0, qAo}, 4, 2) !== e.prod) begin
        nBad++; $display("FAIL monA_product: got %h, required %h", recomb({24'h0, qAo}, 4, 2), e.prod);
      end
      if (e.chk) begin
        nCmp++;
        if (qAo !== e.shares[7:0]) begin
          nBad++; $display("FAIL monA_shares: got %h, required %h", qAo, e.shares[7:0]);
        end
      end
    end
  end

  always @(negedge clk) if (edgeEn && !rst && vB) begin : monB
    exp_t e;
    nCmp++;
    if (sbB.size() == 0) begin
      nBad++; $display("FAIL monB_unexpected: got beat q=%h, required no beat", qBo);
    end else begin
      e = sbB.pop_front();
      if (recomb({8'h0, qBo}, 8, 3) !== e.prod) begin
        nBad++; $display("FAIL monB_product: got %h, required %h", recomb({8'h0, qBo}, 8, 3), e.prod);
      end
    end
  end

  always @(negedge clk) if (edgeEn && !rst && vC) begin : monC
    exp_t e;
    nCmp++;
    if (sbC.size() == 0) begin
      nBad++; $display("FAIL monC_unexpected: got beat q=%h, required no beat", qCo);
    end else begin
      e = sbC.pop_front();
      if (recomb({24'h0, qCo}, 4, 2) !== e.prod) begin
        nBad++; $display("FAIL monC_product: got %h, required %h", recomb({24'h0, qCo}, 4, 2), e.prod);
      end
    end
  end

  always @(negedge clk) if (edgeEn && !rst && vD) begin : monD
    exp_t e;
    nCmp++;
    if (sbD.size() == 0) begin
      nBad++; $display("FAIL monD_unexpected: got beat q=%h, required no beat", qDo);
    end else begin
      e = sbD.pop_front();
      if (recomb({16'h0, qDo}, 4, 4) !== e.prod) begin
        nBad++; $display("FAIL monD_product: got %h, required %h", recomb({16'h0, qDo}, 4, 4), e.prod);
      end
    end
  end

  task automatic drain(input int which, input string tag);
    for (int c = 0; c < 50 && sbSize(which) != 0; c++) @(negedge clk);
    nCmp++;
    if (sbSize(which) != 0) begin
      nBad++; $display("FAIL %s_drain: %0d beats pending, required 0", tag, sbSize(which));
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    nCmp += 7;
    if (vA !== 1'b0)   begin nBad++; $display("FAIL reset_vA: got %b, required 0", vA); end
    if (vB !== 1'b0)   begin nBad++; $display("FAIL reset_vB: got %b, required 0", vB); end
    if (vC !== 1'b0)   begin nBad++; $display("FAIL reset_vC: got %b, required 0", vC); end
    if (vD !== 1'b0)   begin nBad++; $display("FAIL reset_vD: got %b, required 0", vD); end
    if (qAo !== 8'h00) begin nBad++; $display("FAIL reset_qA: got %h, required 00", qAo); end
    if (qBo !== 24'h0) begin nBad++; $display("FAIL reset_qB: got %h, required 0", qBo); end
    if (qCo !== 8'h00) begin nBad++; $display("FAIL reset_qC: got %h, required 00", qCo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spot;
    @(negedge clk);
    xA = 8'h03; yA = 8'h07; zA = '0; ivA = 1'b1;
    sbA.push_back('{prod: 8'h09, shares: 32'h09, chk: 1'b1});
    @(negedge clk);
    nCmp++;
    if (vA !== 1'b1) begin nBad++; $display("FAIL spot1_valid: got %b, required 1", vA); end
    xA = 8'h08; yA = 8'h02;
    sbA.push_back('{prod: 8'h03, shares: 32'h03, chk: 1'b1});
    @(negedge clk);
    nCmp++;
    if (vA !== 1'b1) begin nBad++; $display("FAIL spot2_valid: got %b, required 1", vA); end
    ivA = 1'b0;
    @(negedge clk);
    nCmp++;
    if (vA !== 1'b0) begin nBad++; $display("FAIL spot_idle_valid: got %b, required 0", vA); end
    drain(0, "spot");
  endtask

  task automatic test_exhaustive;
    logic [7:0] p;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        xA = {4'h0, 4'(x)}; yA = {4'h0, 4'(y)}; zA = '0; ivA = 1'b1;
        p = gfRef(8'(x), 8'(y), 4, 9'(GF4_POLY));
        sbA.push_back('{prod: p, shares: {28'h0, p[3:0]}, chk: 1'b1});
      end
    end
    @(negedge clk);
    ivA = 1'b0;
    drain(0, "exhaustive");
  endtask

  task automatic test_z_indep;
    logic [7:0] p;
    p = gfRef(8'h0A, 8'h05, 4, 9'(GF4_POLY));
    for (int z = 0; z < 16; z++) begin
      @(negedge clk);
      xA = 8'h0A; yA = 8'h05; zA = 4'(z); ivA = 1'b1;
      // Zero upper shares: Q0 = X*Y ^ Z and Q1 = Z.
      sbA.push_back('{prod: p, shares: {24'h0, 4'(z), p[3:0] ^ 4'(z)}, chk: 1'b1});
    end
    @(negedge clk);
    ivA = 1'b0;
    drain(0, "zindep");
  endtask

  task automatic test_gf256;
    logic [7:0] m0, m1, n0, n1, x, y;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      m0 = 8'($urandom); m1 = 8'($urandom); n0 = 8'($urandom); n1 = 8'($urandom);
      if (i < 1000) begin x = 8'h57; y = 8'h83; end
      else begin x = 8'($urandom); y = 8'($urandom); end
      xB = {x ^ m0 ^ m1, m1, m0}; yB = {y ^ n0 ^ n1, n1, n0};
      zB = 24'($urandom); ivB = 1'b1;
      sbB.push_back('{prod: (i < 1000) ? 8'hC1 : gfRef(x, y, 8, GF8_POLY), shares: '0, chk: 1'b0});
    end
    @(negedge clk);
    ivB = 1'b0;
    drain(1, "gf256");
  endtask

  task automatic driveC(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] m, n;
    m = 4'($urandom); n = 4'($urandom);
    xC = {m, x ^ m}; yC = {n, y ^ n}; zC = 4'($urandom); ivC = 1'b1;
    sbC.push_back('{prod: gfRef({4'h0, x}, {4'h0, y}, 4, 9'(GF4_POLY)), shares: '0, chk: 1'b0});
  endtask

  task automatic test_stall;
    logic [3:0] bx[6], by[6];
    logic [7:0] frozen;
    for (int i = 0; i < 6; i++) begin bx[i] = 4'($urandom); by[i] = 4'($urandom); end
    frozen = gfRef({4'h0, bx[1]}, {4'h0, by[1]}, 4, 9'(GF4_POLY));
    @(negedge clk); driveC(bx[0], by[0]);
    @(negedge clk);
    nCmp++;
    if (vC !== 1'b0) begin nBad++; $display("FAIL stall_latency: got valid %b after 1 edge, required 0", vC); end
    driveC(bx[1], by[1]);
    @(negedge clk); driveC(bx[2], by[2]);
    @(negedge clk);
    en = 1'b0; ivC = 1'b1; xC = 8'($urandom); yC = 8'($urandom);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      nCmp += 2;
      if (vC !== 1'b1) begin nBad++; $display("FAIL stall_valid: got %b, required 1", vC); end
      if (recomb({24'h0, qCo}, 4, 2) !== frozen) begin
        nBad++; $display("FAIL stall_frozen: got %h, required %h", recomb({24'h0, qCo}, 4, 2), frozen);
      end
    end
    en = 1'b1; driveC(bx[3], by[3]);
    @(negedge clk); driveC(bx[4], by[4]);
    @(negedge clk); driveC(bx[5], by[5]);
    @(negedge clk); ivC = 1'b0;
    drain(2, "stall");
  endtask

  task automatic test_reset_midop;
    @(negedge clk); driveC(4'h3, 4'h7);
    @(negedge clk); driveC(4'h8, 4'h2);
    @(posedge clk); #1;
    rst = 1'b1; ivC = 1'b0;
    #1;
    nCmp += 2;
    if (vC !== 1'b0)   begin nBad++; $display("FAIL midrst_valid: got %b, required 0", vC); end
    if (qCo !== 8'h00) begin nBad++; $display("FAIL midrst_q: got %h, required 00", qCo); end
    sbC.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    nCmp++;
    if (vC !== 1'b0) begin nBad++; $display("FAIL midrst_stale: got valid %b, required 0", vC); end
  endtask

  task automatic test_unpipelined;
    logic [3:0]  x, y;
    logic [11:0] s, t;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      x = 4'($urandom); y = 4'($urandom); s = 12'($urandom); t = 12'($urandom);
      xD = {x ^ s[3:0] ^ s[7:4] ^ s[11:8], s};
      yD = {y ^ t[3:0] ^ t[7:4] ^ t[11:8], t};
      zD = 24'($urandom); ivD = 1'b1;
      sbD.push_back('{prod: gfRef({4'h0, x}, {4'h0, y}, 4, 9'(GF4_POLY)), shares: '0, chk: 1'b0});
      @(negedge clk);
      if (i == 0) begin
        nCmp++;
        if (vD !== 1'b1) begin nBad++; $display("FAIL unpiped_latency: got %b, required 1", vD); end
      end
      ivD = 1'b0; zD = 24'($urandom);
    end
    drain(3, "unpiped");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    ivA = 0; xA = '0; yA = '0; zA = '0;
    ivB = 0; xB = '0; yB = '0; zB = '0;
    ivC = 0; xC = '0; yC = '0; zC = '0;
    ivD = 0; xD = '0; yD = '0; zD = '0;
    test_reset();
    test_spot();
    test_exhaustive();
    test_z_indep();
    test_gf256();
    test_stall();
    test_reset_midop();
    test_unpipelined();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
